// File: rtl/student_pc_pkg.sv
// Shared definitions for the fetch-stage program counter and its return-address stack.
package student_pc_pkg;

    // Operation chosen for the current cycle, after priority resolution.
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_LOAD = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } op_e;

    // PC value after reset; cast to the instance width where used.
    localparam int unsigned RESET_PC = 32'd0;

endpackage

// File: rtl/student_ras.sv
// Return-address stack: DEPTH x WIDTH register array plus an entry count.
// Push-when-full and pop-when-empty are silently ignored; error reporting
// belongs to the caller.
module student_ras
    import student_pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int SPW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [SPW-1:0]   depth,
    output logic             empty,
    output logic             full
);

    // Index width into the array; at least one bit even for a single entry.
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack_r [DEPTH];
    logic [SPW-1:0]   count_r;
    logic [SPW-1:0]   top_pos_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Status decode, guarded push/pop and top-of-stack read.
    always_comb begin
        empty     = (count_r == SPW'(0));
        full      = (count_r == SPW'(DEPTH));
        do_pop_s  = pop && !empty;
        do_push_s = push && !pop && !full;
        top_pos_s = count_r - SPW'(1);
        top       = stack_r[top_pos_s[IDXW-1:0]];
    end

    assign depth = count_r;

    // Stack storage and entry count; a push writes the slot just above the top.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= SPW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= WIDTH'(0);
            end
        end else if (do_push_s) begin
            stack_r[count_r[IDXW-1:0]] <= push_data;
            count_r                    <= count_r + SPW'(1);
        end else if (do_pop_s) begin
            count_r <= count_r - SPW'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/student_pc_ras.sv
// Fetch-stage program counter with call/return support through an integrated
// return-address stack and sticky overflow/underflow flags.
module student_pc_ras
    import student_pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int SPW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             ret,
    input  logic             call,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] out,
    output logic [SPW-1:0]   depth,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] pc_r;
    logic             ovf_r;
    logic             unf_r;
    op_e              op_s;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH-1:0] top_s;
    logic             push_s;
    logic             pop_s;
    logic             ovf_nxt_s;
    logic             unf_nxt_s;

    // Return address and increment share the same wrapping PC+1.
    assign pc_inc_s = pc_r + WIDTH'(1);

    // Priority encoder: ret > call > load > inc > hold; a stall forces hold.
    always_comb begin
        op_s = OP_HOLD;
        if (!en) begin
            op_s = OP_HOLD;
        end else if (ret) begin
            op_s = OP_RET;
        end else if (call) begin
            op_s = OP_CALL;
        end else if (load) begin
            op_s = OP_LOAD;
        end else if (inc) begin
            op_s = OP_INC;
        end else begin
            op_s = OP_HOLD;
        end
    end

    // Next-PC mux, stack control and sticky error flag set conditions.
    always_comb begin
        pc_nxt_s  = pc_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        ovf_nxt_s = ovf_r;
        unf_nxt_s = unf_r;
        case (op_s)
            OP_RET: begin
                if (empty) begin
                    unf_nxt_s = 1'b1;
                end else begin
                    pop_s    = 1'b1;
                    pc_nxt_s = top_s;
                end
            end
            OP_CALL: begin
                pc_nxt_s = in;
                if (full) begin
                    ovf_nxt_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end
            OP_LOAD: pc_nxt_s = in;
            OP_INC:  pc_nxt_s = pc_inc_s;
            OP_HOLD: pc_nxt_s = pc_r;
            default: pc_nxt_s = pc_r;
        endcase
    end

    // PC and sticky flag registers; reset wins over every request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_r  <= WIDTH'(RESET_PC);
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            pc_r  <= pc_nxt_s;
            ovf_r <= ovf_nxt_s;
            unf_r <= unf_nxt_s;
        end
    end

    student_ras #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top       (top_s),
        .depth     (depth),
        .empty     (empty),
        .full      (full)
    );

    assign out       = pc_r;
    assign overflow  = ovf_r;
    assign underflow = unf_r;

endmodule

// File: tb/tb_student_pc_ras.sv
// Scoreboard bench for student_pc_ras: directed scenarios plus random ops,
// checked against a queue-based model of the PC and return stack.
module tb_student_pc_ras;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int SPW   = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] in;
    logic             en, ret, call, load, inc;
    logic [WIDTH-1:0] out;
    logic [SPW-1:0]   depth;
    logic             empty, full, overflow, underflow;

    typedef struct {
        logic [WIDTH-1:0] pc;
        int               dep;
        bit               ovf;
        bit               unf;
        string            name;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_stack[$];
    bit               m_ovf;
    bit               m_unf;

    int n_vec = 0;
    int n_bad = 0;

    student_pc_ras #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in        (in),
        .en        (en),
        .ret       (ret),
        .call      (call),
        .load      (load),
        .inc       (inc),
        .out       (out),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus and queue the state the model predicts after the edge.
    task automatic step(input bit r_n, input bit e, input bit rt, input bit cl,
                        input bit ld, input bit ic, input logic [WIDTH-1:0] d,
                        input string nm);
        exp_t x;
        @(negedge clk);
        reset_n = r_n; en = e; ret = rt; call = cl; load = ld; inc = ic; in = d;
        if (!r_n) begin
            m_pc = '0;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (e) begin
            if (rt) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else m_unf = 1'b1;
            end else if (cl) begin
                if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 16'd1);
                else m_ovf = 1'b1;
                m_pc = d;
            end else if (ld) begin
                m_pc = d;
            end else if (ic) begin
                m_pc = m_pc + 16'd1;
            end
        end
        x.pc = m_pc; x.dep = m_stack.size(); x.ovf = m_ovf; x.unf = m_unf; x.name = nm;
        sb.push_back(x);
    endtask

    // Monitor: after every edge, pop the oldest expectation and compare.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                n_vec++;
                if (out !== x.pc || depth !== SPW'(x.dep) || empty !== (x.dep == 0) ||
                    full !== (x.dep == DEPTH) || overflow !== x.ovf || underflow !== x.unf) begin
                    n_bad++;
                    $display("FAIL %s: got out=%h depth=%0d empty=%b full=%b ovf=%b unf=%b, want out=%h depth=%0d empty=%b full=%b ovf=%b unf=%b",
                             x.name, out, depth, empty, full, overflow, underflow,
                             x.pc, x.dep, (x.dep == 0), (x.dep == DEPTH), x.ovf, x.unf);
                end
            end
        end
    end

    initial begin
        bit r_n, e, rt, cl, ld, ic;
        logic [WIDTH-1:0] d;
        int waited;
        reset_n = 1'b0; en = 1'b0; ret = 1'b0; call = 1'b0; load = 1'b0; inc = 1'b0; in = '0;
        m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;

        // reset then count
        step(0, 1, 0, 1, 0, 1, 16'h1234, "reset_with_call");
        step(1, 1, 0, 0, 0, 1, 16'h0000, "inc1");
        step(1, 1, 0, 0, 0, 1, 16'h0000, "inc2");
        step(1, 1, 0, 0, 0, 1, 16'h0000, "inc3");
        // wrap
        step(1, 1, 0, 0, 1, 1, 16'hFFFF, "load_ffff");
        step(1, 1, 0, 0, 0, 1, 16'h0000, "inc_wrap");
        // nested call/ret
        step(1, 1, 0, 0, 1, 0, 16'd5,   "load5");
        step(1, 1, 0, 1, 1, 1, 16'd100, "call100");
        step(1, 1, 0, 1, 0, 0, 16'd200, "call200");
        step(1, 1, 1, 0, 0, 0, 16'd0,   "ret_101");
        step(1, 1, 1, 0, 0, 0, 16'd0,   "ret_6");
        // overflow
        step(1, 1, 0, 1, 0, 0, 16'd100, "fill1");
        step(1, 1, 0, 1, 0, 0, 16'd200, "fill2");
        step(1, 1, 0, 1, 0, 0, 16'd300, "call_full");
        step(1, 1, 1, 0, 0, 0, 16'd0,   "ret_after_ovf");
        step(1, 1, 1, 0, 0, 0, 16'd0,   "ret_drain");
        // underflow then reset
        step(1, 1, 0, 0, 1, 0, 16'd7,   "load7");
        step(1, 1, 1, 1, 1, 1, 16'd9,   "ret_empty");
        step(1, 1, 0, 0, 0, 0, 16'd0,   "hold_flags");
        step(0, 1, 1, 0, 0, 0, 16'd0,   "reset_clears");
        // call at all-ones pushes 0
        step(1, 1, 0, 0, 1, 0, 16'hFFFF, "load_ones");
        step(1, 1, 0, 1, 0, 0, 16'd3,    "call_at_ones");
        step(1, 1, 1, 0, 0, 0, 16'd0,    "ret_to_zero");
        // stall
        step(1, 1, 0, 0, 1, 0, 16'd9,    "load9");
        step(1, 1, 0, 1, 0, 0, 16'd50,   "call50");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 1, 1, 16'd77, "stall");
        step(1, 0, 1, 0, 0, 0, 16'd0,    "stall_ret");
        step(1, 1, 1, 1, 1, 0, 16'd88,   "ret_wins");
        step(1, 1, 1, 0, 0, 0, 16'd0,    "ret_unf_after_stall");
        step(1, 0, 0, 0, 0, 0, 16'd0,    "stall_flag_hold");

        // random
        for (int i = 0; i < 1500; i++) begin
            r_n = ($urandom_range(0, 59) != 0);
            e   = ($urandom_range(0, 9) != 0);
            rt  = ($urandom_range(0, 3) == 0);
            cl  = ($urandom_range(0, 2) == 0);
            ld  = ($urandom_range(0, 3) == 0);
            ic  = $urandom_range(0, 1) == 1;
            d   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            step(r_n, e, rt, cl, ld, ic, d, "random");
        end

        @(negedge clk);
        reset_n = 1'b1; en = 1'b0;
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
